// File: rtl/rw_req_arbiter.sv
// N-master request arbiter in front of axi_rw: registered one-hot grant, payload capture, per-master ID.
// Define RW_ARB_FIXED_PRIO_EN for fixed priority (highest index wins) instead of round-robin.
module rw_req_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int ID_W        = 4,
  parameter int ID_BASE     = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_valid_i,
  input  logic [NUM_MASTERS-1:0]        m_req_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
  input  logic [NUM_MASTERS*2-1:0]      m_size_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata_i,
  output logic [NUM_MASTERS-1:0]        m_ready_o,
  output logic [DATA_W-1:0]             m_rdata_o,
  output logic [1:0]                    m_resp_o,
  output logic                          rw_valid_o,
  input  logic                          rw_ready_i,
  output logic                          rw_req_o,
  output logic [ADDR_W-1:0]             rw_addr_o,
  output logic [1:0]                    rw_size_o,
  output logic [DATA_W-1:0]             rw_data_write_o,
  input  logic [DATA_W-1:0]             rw_data_read_i,
  input  logic [1:0]                    rw_resp_i,
  output logic [ID_W-1:0]               rw_id_o,
  output logic [NUM_MASTERS-1:0]        grant_o,
  output logic                          busy_o
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   req_q, req_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [1:0]             size_q, size_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [IDX_W-1:0]       sel;
  logic                   busy;
  logic                   done;

`ifndef RW_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]       last_q, last_d;
  logic [IDX_W:0]         cand;
  logic                   found;
`endif

  // Winner selection; only consumed while IDLE.
  always_comb begin
    sel = '0;
`ifdef RW_ARB_FIXED_PRIO_EN
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (m_valid_i[i]) sel = IDX_W'(i);
    end
`else
    cand  = '0;
    found = 1'b0;
    // Scan last+1 .. last+N with wrap; cand is one bit wider so the sum cannot overflow.
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      cand = {1'b0, last_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_MASTERS)) cand = cand - (IDX_W+1)'(NUM_MASTERS);
      if (!found && m_valid_i[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        sel   = cand[IDX_W-1:0];
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    req_d   = req_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
`ifndef RW_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|m_valid_i) begin
          state_d = ST_BUSY;
          grant_d = NUM_MASTERS'(1) << sel;
          idx_d   = sel;
          req_d   = m_req_i[sel];
          addr_d  = m_addr_i[int'(sel)*ADDR_W +: ADDR_W];
          size_d  = m_size_i[int'(sel)*2 +: 2];
          wdata_d = m_wdata_i[int'(sel)*DATA_W +: DATA_W];
        end
      end
      default: begin
        if (rw_ready_i) begin
          state_d = ST_IDLE;
          grant_d = '0;
`ifndef RW_ARB_FIXED_PRIO_EN
          last_d  = idx_q;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
    end
  end

`ifndef RW_ARB_FIXED_PRIO_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) last_q <= IDX_W'(NUM_MASTERS - 1);
    else        last_q <= last_d;
  end
`endif

  assign busy = (state_q == ST_BUSY);
  assign done = busy & rw_ready_i;

  // Payload and ID are gated so IDLE presents the same all-zero view as reset.
  assign rw_valid_o      = busy;
  assign busy_o          = busy;
  assign grant_o         = grant_q;
  assign rw_req_o        = busy & req_q;
  assign rw_addr_o       = busy ? addr_q  : '0;
  assign rw_size_o       = busy ? size_q  : '0;
  assign rw_data_write_o = busy ? wdata_q : '0;
  assign rw_id_o         = busy ? (ID_W'(ID_BASE) + ID_W'(idx_q)) : '0;

  assign m_ready_o = done ? grant_q        : '0;
  assign m_rdata_o = done ? rw_data_read_i : '0;
  assign m_resp_o  = done ? rw_resp_i      : '0;

endmodule
